// File: rtl/rv32_alu_pkg.sv
// Shared ALU select encodings, R-type decode constants and controller FSM states.
// Used by rtype_exec_ctrl and by the ALU it drives.
package rv32_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100
    } alu_sel_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} exec_state_e;

    typedef struct packed {
        logic     legal;
        alu_sel_e sel;
    } dec_t;

    // Unsupported encodings come back with legal=0 and sel=ADD so the ALU input is benign.
    function automatic dec_t decode_rtype(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] f7;
        logic [2:0] f3;
        d.legal = 1'b0;
        d.sel   = ALU_ADD;
        f7      = ins[31:25];
        f3      = ins[14:12];
        if (ins[6:0] == OPC_RTYPE) begin
            d.legal = 1'b1;
            if      (f7 == F7_BASE && f3 == F3_ADDSUB) d.sel = ALU_ADD;
            else if (f7 == F7_ALT  && f3 == F3_ADDSUB) d.sel = ALU_SUB;
            else if (f7 == F7_BASE && f3 == F3_AND)    d.sel = ALU_AND;
            else if (f7 == F7_BASE && f3 == F3_OR)     d.sel = ALU_OR;
            else if (f7 == F7_BASE && f3 == F3_XOR)    d.sel = ALU_XOR;
            else                                       d.legal = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// NREGS x XLEN register file: two operand reads, one debug read, one synchronous write.
// x0 is hardwired to zero; synchronous active-low clear of every entry.
module rv32_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] dbg_rdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1    = (raddr1    == 5'd0) ? '0 : regs[raddr1];
    assign rdata2    = (raddr2    == 5'd0) ? '0 : regs[raddr2];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/rtype_exec_ctrl.sv
// RV32I R-type issue/writeback controller: IDLE -> DECODE -> EXEC -> WB, one instruction in flight.
// Optional RTYPE_RETIRE_CNT_EN adds a retire_cnt output counting legal retirements.
module rtype_exec_ctrl
    import rv32_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [3:0]      ALU_sel,
    output logic [XLEN-1:0] reg1,
    output logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] ALU_Out,
    input  logic            ext_we,
    input  logic [4:0]      ext_waddr,
    input  logic [XLEN-1:0] ext_wdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            done,
`ifdef RTYPE_RETIRE_CNT_EN
    output logic [XLEN-1:0] retire_cnt,
`endif
    output logic            illegal
);

    exec_state_e     state_q, state_d;
    logic [31:0]     instr_q;
    alu_sel_e        alu_sel_q;
    logic [XLEN-1:0] reg1_q, reg2_q, result_q;
    logic            illegal_q;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    dec_t            dec;

    assign dec = decode_rtype(instr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= '0;
            alu_sel_q <= ALU_ADD;
            reg1_q    <= '0;
            reg2_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (state_q == IDLE && instr_valid) instr_q <= instr;
            if (state_q == DECODE) begin
                alu_sel_q <= dec.legal ? dec.sel : ALU_ADD;
                reg1_q    <= rdata1;
                reg2_q    <= rdata2;
                illegal_q <= ~dec.legal;
            end
            if (state_q == EXEC) result_q <= ALU_Out;
        end
    end

    // Preloads and writebacks never collide: preloads are honoured only in IDLE.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ext_waddr;
        rf_wdata = ext_wdata;
        if (state_q == IDLE && ext_we) begin
            rf_we = 1'b1;
        end else if (state_q == WB && !illegal_q) begin
            rf_we    = 1'b1;
            rf_waddr = instr_q[11:7];
            rf_wdata = result_q;
        end
    end

    rv32_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr1    (instr_q[19:15]),
        .raddr2    (instr_q[24:20]),
        .dbg_raddr (dbg_raddr),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .dbg_rdata (dbg_rdata)
    );

    assign instr_ready = (state_q == IDLE);
    assign ALU_sel     = alu_sel_q;
    assign reg1        = reg1_q;
    assign reg2        = reg2_q;
    assign done        = (state_q == WB);
    assign illegal     = (state_q == WB) && illegal_q;

`ifdef RTYPE_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n)                   retire_cnt_q <= '0;
        else if (done && !illegal_q)  retire_cnt_q <= retire_cnt_q + XLEN'(1);
    end
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Self-checking bench for rtype_exec_ctrl: directed spec cases plus random R-type traffic
// against an architectural register-file model; the ALU is modelled behaviourally here.
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, instr_valid, instr_ready, ext_we, done, illegal;
    logic [31:0] instr, reg1, reg2, alu_out, ext_wdata, dbg_rdata;
    logic [3:0]  ALU_sel;
    logic [4:0]  ext_waddr, dbg_raddr;
`ifdef RTYPE_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] mregs [32];
    logic [31:0] exp_retire;

    always #5 clk = ~clk;

    rtype_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ALU_sel(ALU_sel), .reg1(reg1), .reg2(reg2), .ALU_Out(alu_out),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .done(done),
`ifdef RTYPE_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .illegal(illegal)
    );

    // Behavioural ALU sitting on the other side of the interface.
    always_comb begin
        case (ALU_sel)
            4'd0:    alu_out = reg1 + reg2;
            4'd1:    alu_out = reg1 - reg2;
            4'd2:    alu_out = reg1 & reg2;
            4'd3:    alu_out = reg1 | reg2;
            4'd4:    alu_out = reg1 ^ reg2;
            default: alu_out = 32'h0;
        endcase
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    // Reference: architectural meaning of an instruction word.
    function automatic void model(input logic [31:0] ins, output logic legal,
                                  output logic [3:0] sel, output logic [31:0] res);
        logic [31:0] a, b;
        a = (ins[19:15] == 0) ? 32'h0 : mregs[ins[19:15]];
        b = (ins[24:20] == 0) ? 32'h0 : mregs[ins[24:20]];
        legal = 1'b0; sel = 4'd0; res = 32'h0;
        if (ins[6:0] == 7'b0110011) begin
            legal = 1'b1;
            case ({ins[31:25], ins[14:12]})
                {7'h00, 3'b000}: begin sel = 4'd0; res = a + b; end
                {7'h20, 3'b000}: begin sel = 4'd1; res = a - b; end
                {7'h00, 3'b111}: begin sel = 4'd2; res = a & b; end
                {7'h00, 3'b110}: begin sel = 4'd3; res = a | b; end
                {7'h00, 3'b100}: begin sel = 4'd4; res = a ^ b; end
                default:         legal = 1'b0;
            endcase
        end
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        @(negedge clk);
        ext_we = 1'b0;
        if (a != 0) mregs[a] = d;
    endtask

    // Issue one instruction (optionally with a coincident preload) and walk it to retirement.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic pre, input logic [4:0] pa, input logic [31:0] pd);
        logic legal; logic [3:0] sel; logic [31:0] res, a, b;
        @(negedge clk);
        total++;
        if (instr_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b exp 1", tag, instr_ready); end
        instr_valid = 1'b1; instr = ins;
        ext_we = pre; ext_waddr = pa; ext_wdata = pd;
        if (pre && pa != 0) mregs[pa] = pd;
        model(ins, legal, sel, res);
        a = (ins[19:15] == 0) ? 32'h0 : mregs[ins[19:15]];
        b = (ins[24:20] == 0) ? 32'h0 : mregs[ins[24:20]];
        @(negedge clk);
        instr_valid = 1'b0; ext_we = 1'b0; instr = $urandom;
        total++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL %s decode_flags: got ready=%b done=%b exp 0 0", tag, instr_ready, done);
        end
        @(negedge clk);
        total++;
        if (ALU_sel !== sel) begin bad++; $display("FAIL %s alu_sel: got %h exp %h", tag, ALU_sel, sel); end
        if (legal) begin
            total++;
            if (reg1 !== a || reg2 !== b) begin
                bad++; $display("FAIL %s operands: got %h %h exp %h %h", tag, reg1, reg2, a, b);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || illegal !== !legal) begin
            bad++; $display("FAIL %s retire: got done=%b illegal=%b exp 1 %b", tag, done, illegal, !legal);
        end
        if (legal && ins[11:7] != 0) mregs[ins[11:7]] = res;
        if (legal) exp_retire = exp_retire + 1;
        @(negedge clk);
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL %s back_idle: got ready=%b done=%b exp 1 0", tag, instr_ready, done);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i); #1;
            total++;
            if (dbg_rdata !== mregs[i]) begin
                bad++; $display("FAIL %s x%0d: got %h exp %h", tag, i, dbg_rdata, mregs[i]);
            end
        end
`ifdef RTYPE_RETIRE_CNT_EN
        total++;
        if (retire_cnt !== exp_retire) begin
            bad++; $display("FAIL %s retire_cnt: got %0d exp %0d", tag, retire_cnt, exp_retire);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_retire = 32'h0;
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got ready=%b done=%b illegal=%b exp 1 0 0", instr_ready, done, illegal);
        end
        total++;
        if (ALU_sel !== 4'd0 || reg1 !== 32'h0 || reg2 !== 32'h0) begin
            bad++; $display("FAIL reset_datapath: got sel=%h r1=%h r2=%h exp 0 0 0", ALU_sel, reg1, reg2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_ops();
        preload(5'd1, 32'd5); preload(5'd2, 32'd3);
        run_instr("add", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33), 1'b0, 5'd0, 32'h0);
        preload(5'd1, 32'd3); preload(5'd2, 32'd5);
        run_instr("sub", enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33), 1'b0, 5'd0, 32'h0);
        preload(5'd1, 32'hFFFF_FFFF); preload(5'd2, 32'd1);
        run_instr("add_wrap", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33), 1'b0, 5'd0, 32'h0);
        preload(5'd5, 32'hF0F0_F0F0); preload(5'd6, 32'h0FF0_0FF0);
        run_instr("and", enc(7'h00, 5'd6, 5'd5, 3'b111, 5'd7, 7'h33), 1'b0, 5'd0, 32'h0);
        run_instr("or",  enc(7'h00, 5'd6, 5'd5, 3'b110, 5'd8, 7'h33), 1'b0, 5'd0, 32'h0);
        run_instr("xor", enc(7'h00, 5'd6, 5'd5, 3'b100, 5'd9, 7'h33), 1'b0, 5'd0, 32'h0);
        // Fixed expectations straight from the arithmetic, independent of the model.
        total++;
        if (mregs[3] !== 32'h0 || mregs[4] !== 32'hFFFF_FFFE || mregs[7] !== 32'h00F0_00F0 ||
            mregs[8] !== 32'hFFF0_FFF0 || mregs[9] !== 32'hFF00_FF00) begin
            bad++; $display("FAIL golden_values: got x3=%h x4=%h x7=%h x8=%h x9=%h", mregs[3], mregs[4], mregs[7], mregs[8], mregs[9]);
        end
    endtask

    task automatic test_illegal_x0();
        run_instr("mul", enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd10, 7'h33), 1'b0, 5'd0, 32'h0);
        run_instr("opimm", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd10, 7'h13), 1'b0, 5'd0, 32'h0);
        run_instr("add_x0", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33), 1'b0, 5'd0, 32'h0);
        run_instr("same_reg", enc(7'h00, 5'd5, 5'd5, 3'b000, 5'd5, 7'h33), 1'b0, 5'd0, 32'h0);
        run_instr("pre_accept", enc(7'h00, 5'd0, 5'd12, 3'b000, 5'd11, 7'h33), 1'b1, 5'd12, 32'hCAFE_0123);
    endtask

    task automatic test_back_to_back();
        logic [31:0] x7_0, x9_0, x1v;
        x7_0 = mregs[7]; x9_0 = mregs[9]; x1v = mregs[1];
        @(negedge clk);
        instr_valid = 1'b1; instr = enc(7'h00, 5'd1, 5'd7, 3'b000, 5'd7, 7'h33);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ext_we = (k == 2); ext_waddr = 5'd9; ext_wdata = 32'hDEAD_BEEF;
            total++;
            if (instr_ready !== (k % 4 == 0) || done !== (k % 4 == 3)) begin
                bad++; $display("FAIL b2b cycle%0d: got ready=%b done=%b exp %b %b", k, instr_ready, done, k % 4 == 0, k % 4 == 3);
            end
        end
        instr_valid = 1'b0; ext_we = 1'b0;
        mregs[7] = x7_0 + 3 * x1v;
        exp_retire = exp_retire + 3;
        dbg_raddr = 5'd7; #1;
        total++;
        if (dbg_rdata !== mregs[7]) begin bad++; $display("FAIL b2b_accum: got %h exp %h", dbg_rdata, mregs[7]); end
        dbg_raddr = 5'd9; #1;
        total++;
        if (dbg_rdata !== x9_0) begin bad++; $display("FAIL b2b_ext_we_exec: got %h exp %h", dbg_rdata, x9_0); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  f7, opc;
        logic [2:0]  f3;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) preload(5'($urandom_range(0, 31)), $urandom);
            opc = 7'h33; f7 = 7'h00;
            case ($urandom_range(0, 7))
                0: f3 = 3'b000;
                1: begin f3 = 3'b000; f7 = 7'h20; end
                2: f3 = 3'b111;
                3: f3 = 3'b110;
                4: f3 = 3'b100;
                5: begin f3 = 3'($urandom_range(0, 7)); f7 = 7'h01; end
                6: begin f3 = 3'b001; end
                default: begin f3 = 3'b000; opc = 7'h13; end
            endcase
            ins = enc(f7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
                      5'($urandom_range(0, 31)), opc);
            run_instr("rand", ins, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    task automatic test_reset_exec();
        preload(5'd1, 32'd10); preload(5'd2, 32'd20);
        @(negedge clk);
        instr_valid = 1'b1; instr = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd13, 7'h33);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || ALU_sel !== 4'd0 || reg1 !== 32'h0) begin
            bad++; $display("FAIL reset_exec_state: got ready=%b done=%b sel=%h r1=%h exp 1 0 0 0", instr_ready, done, ALU_sel, reg1);
        end
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_retire = 32'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i); #1;
            total++;
            if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_exec x%0d: got %h exp 0", i, dbg_rdata); end
        end
`ifdef RTYPE_RETIRE_CNT_EN
        total++;
        if (retire_cnt !== 32'h0) begin bad++; $display("FAIL reset_exec retire_cnt: got %0d exp 0", retire_cnt); end
`endif
        run_instr("post_reset", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd13, 7'h33), 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0;
        ext_we = 1'b0; ext_waddr = 5'd0; ext_wdata = 32'h0; dbg_raddr = 5'd0;
        exp_retire = 32'h0;
        test_reset();
        test_alu_ops();
        test_illegal_x0();
        test_back_to_back();
        test_random();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
